// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch hazard / resolve controller.
// Branches are resolved in ID against a 32-bit comparator. A branch waits
// (stalls) until its source operands are available in the regfile or on
// the MEM-stage ALU-result forwarding path, then redirects the PC when
// cmp_taken is set.
// Optional feature: define BRANCH_STATS_EN to build the br_total/br_taken
// saturating statistics counters. Otherwise both ports are tied to 0.
module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        cmp_taken,
  input  logic        ext_flush,
  output logic        stall,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        pc_sel_branch,
  output logic        flush_if_id,
  output logic [15:0] br_total,
  output logic [15:0] br_taken
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t     r_state;
  logic [1:0] r_cnt;

  state_t     w_state_n;
  logic [1:0] w_cnt_n;
  logic       w_stall;
  logic       w_resolve;
  logic       w_is_br;
  logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic       w_ex_hit, w_mem_hit;
  logic [1:0] w_s;

  // Branch decode and producer matching; r0 is hardwired zero and never hazards.
  assign w_is_br   = id_valid && (id_opcode >= 6'h06) && (id_opcode <= 6'h0B);
  assign w_rs_ex   = (id_rs != 5'd0) && (id_rs == ex_rd);
  assign w_rt_ex   = (id_rt != 5'd0) && (id_rt == ex_rd);
  assign w_rs_mem  = (id_rs != 5'd0) && (id_rs == mem_rd);
  assign w_rt_mem  = (id_rt != 5'd0) && (id_rt == mem_rd);
  assign w_ex_hit  = w_rs_ex || w_rt_ex;
  assign w_mem_hit = w_rs_mem || w_rt_mem;

  // Stall count: a load in EX needs two bubbles, an ALU op in EX or a load
  // in MEM needs one (its result then reaches the MEM ALU-result path / WB).
  assign w_s = (ex_memread && w_ex_hit)                                  ? 2'd2 :
               ((ex_regwrite && w_ex_hit) || (mem_memread && w_mem_hit)) ? 2'd1 :
                                                                           2'd0;

  // State and wait counter; reset and external flush both drop back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next-state and Mealy stall/resolve decisions.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_stall   = 1'b0;
    w_resolve = 1'b0;
    if (rst) begin
      w_state_n = IDLE;
      w_cnt_n   = 2'd0;
    end else if (ext_flush) begin
      w_state_n = IDLE;
      w_cnt_n   = 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_br) begin
            if (w_s == 2'd0) begin
              w_resolve = 1'b1;
            end else begin
              w_stall   = 1'b1;
              w_cnt_n   = w_s - 2'd1;
              // S=1 stays in IDLE and simply re-evaluates next cycle
              w_state_n = (w_s == 2'd2) ? WAIT : IDLE;
            end
          end
        end
        WAIT: begin
          // Counter runs blind here: ID/EX/MEM inputs are ignored until it expires
          w_stall = 1'b1;
          if (r_cnt <= 2'd1) begin
            w_cnt_n   = 2'd0;
            w_state_n = IDLE;
          end else begin
            w_cnt_n = r_cnt - 2'd1;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = 2'd0;
        end
      endcase
    end
  end

  assign stall         = w_stall;
  assign pc_sel_branch = w_resolve && cmp_taken;
  assign flush_if_id   = w_resolve && cmp_taken;
  // Only a non-load MEM producer has its result on the ALU-result path.
  assign fwd_a_sel = (w_resolve && mem_regwrite && !mem_memread && w_rs_mem) ? 2'b01 : 2'b00;
  assign fwd_b_sel = (w_resolve && mem_regwrite && !mem_memread && w_rt_mem) ? 2'b01 : 2'b00;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_total;
  logic [15:0] r_taken;

  // Saturating resolve / taken statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= 16'd0;
      r_taken <= 16'd0;
    end else if (w_resolve) begin
      if (r_total != 16'hFFFF) r_total <= r_total + 16'd1;
      if (cmp_taken && (r_taken != 16'hFFFF)) r_taken <= r_taken + 16'd1;
    end
  end

  assign br_total = r_total;
  assign br_taken = r_taken;
`else
  assign br_total = 16'd0;
  assign br_taken = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: per-cycle expected outputs
// are queued with the stimulus and popped/compared on the falling edge.
module tb_branch_resolve_ctrl;

  logic        clk, rst;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt;
  logic        ex_regwrite, ex_memread;
  logic [4:0]  ex_rd;
  logic        mem_regwrite, mem_memread;
  logic [4:0]  mem_rd;
  logic        cmp_taken, ext_flush;
  logic        stall, pc_sel_branch, flush_if_id;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] br_total, br_taken;

  int n_cmp = 0;
  int n_err = 0;
  int exp_tot = 0;
  int exp_tkn = 0;

  logic [7:0] q[$];
  string      tq[$];

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_rd(mem_rd), .cmp_taken(cmp_taken),
    .ext_flush(ext_flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .pc_sel_branch(pc_sel_branch),
    .flush_if_id(flush_if_id), .br_total(br_total), .br_taken(br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected vector: {res, stall, pc_sel, flush, fwd_a[1:0], fwd_b[1:0]}.
  // res is not a port; it feeds the bench's own statistics tally.
  function automatic logic [7:0] ex(input bit res, input bit st, input bit tk,
                                    input logic [1:0] fa, input logic [1:0] fb);
    return {res, st, tk, tk, fa, fb};
  endfunction

  task automatic clr();
    id_valid = 0; id_opcode = 0; id_rs = 0; id_rt = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    cmp_taken = 0; ext_flush = 0;
  endtask

  task automatic br(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input bit tk);
    id_valid = 1; id_opcode = op; id_rs = rs; id_rt = rt; cmp_taken = tk;
  endtask

  // Inputs are already applied (1 time unit after posedge); push the
  // expectation, compare on the falling edge, then advance past the next edge.
  task automatic step(input logic [7:0] e, input string tag);
    logic [7:0] x;
    string      t;
    q.push_back(e);
    tq.push_back(tag);
    @(negedge clk);
    x = q.pop_front();
    t = tq.pop_front();
    chk(t, {25'd0, stall, pc_sel_branch, flush_if_id, fwd_a_sel, fwd_b_sel},
        {25'd0, x[6:0]});
    if (rst) begin
      exp_tot = 0; exp_tkn = 0;
    end else if (x[7]) begin
      exp_tot++;
      if (x[5]) exp_tkn++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clr();
    rst = 1;
    // Reset forces outputs low even with a taken, hazard-free branch in ID
    br(6'h06, 5'd1, 5'd2, 1'b1);
    mem_regwrite = 1; mem_rd = 5'd1;
    @(posedge clk); #1;
    step(ex(0,0,0,2'b00,2'b00), "reset_outputs");
    chk("reset_br_total", {16'd0, br_total}, 32'd0);
    chk("reset_br_taken", {16'd0, br_taken}, 32'd0);
    rst = 0; clr();

    // BEQ, no hazard, taken: same-cycle resolve
    br(6'h06, 5'd1, 5'd2, 1'b1);
    step(ex(1,0,1,2'b00,2'b00), "beq_taken_nohaz");

    // Non-branch opcodes and invalid ID produce nothing, even with hazards
    clr(); br(6'h05, 5'd5, 5'd0, 1'b1); ex_memread = 1; ex_rd = 5'd5;
    step(ex(0,0,0,2'b00,2'b00), "op05_ignored");
    clr(); br(6'h0C, 5'd5, 5'd0, 1'b1); ex_regwrite = 1; ex_rd = 5'd5;
    step(ex(0,0,0,2'b00,2'b00), "op0c_ignored");
    clr(); br(6'h06, 5'd5, 5'd0, 1'b1); id_valid = 0; ex_memread = 1; ex_rd = 5'd5;
    step(ex(0,0,0,2'b00,2'b00), "invalid_ignored");

    // BNE rs=5 behind a load in EX: two stall cycles, resolve in the third
    clr(); br(6'h07, 5'd5, 5'd3, 1'b0); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5;
    step(ex(0,1,0,2'b00,2'b00), "load_stall_c1");
    // WAIT ignores ID/EX/MEM changes (non-branch opcode, new hazard)
    id_opcode = 6'h00; ex_rd = 5'd3;
    step(ex(0,1,0,2'b00,2'b00), "load_stall_c2");
    clr(); br(6'h07, 5'd5, 5'd3, 1'b0);
    step(ex(1,0,0,2'b00,2'b00), "load_resolve_nt");

    // BGT rt=7 behind an ALU op in EX: one stall, then forward from MEM on B
    clr(); br(6'h08, 5'd4, 5'd7, 1'b1); ex_regwrite = 1; ex_rd = 5'd7;
    step(ex(0,1,0,2'b00,2'b00), "alu_stall_c1");
    clr(); br(6'h08, 5'd4, 5'd7, 1'b1); mem_regwrite = 1; mem_rd = 5'd7;
    step(ex(1,0,1,2'b00,2'b01), "alu_resolve_fwdb");

    // Load in MEM matching rs: one stall, then regfile path
    clr(); br(6'h0B, 5'd9, 5'd0, 1'b0); mem_memread = 1; mem_regwrite = 1; mem_rd = 5'd9;
    step(ex(0,1,0,2'b00,2'b00), "memload_stall");
    clr(); br(6'h0B, 5'd9, 5'd0, 1'b0);
    step(ex(1,0,0,2'b00,2'b00), "memload_resolve");

    // r0 never matches: no stall and no forward
    clr(); br(6'h0A, 5'd0, 5'd0, 1'b1); ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd0;
    mem_regwrite = 1; mem_rd = 5'd0;
    step(ex(1,0,1,2'b00,2'b00), "r0_no_hazard");

    // MEM ALU producer on both operands: immediate resolve, both forwarded
    clr(); br(6'h09, 5'd3, 5'd3, 1'b0); mem_regwrite = 1; mem_rd = 5'd3;
    ex_regwrite = 1; ex_rd = 5'd4;
    step(ex(1,0,0,2'b01,2'b01), "fwd_both");

    // ext_flush during WAIT: no stall that cycle, IDLE afterwards
    clr(); br(6'h06, 5'd6, 5'd0, 1'b1); ex_memread = 1; ex_rd = 5'd6;
    step(ex(0,1,0,2'b00,2'b00), "flush_stall_c1");
    ext_flush = 1;
    step(ex(0,0,0,2'b00,2'b00), "flush_in_wait");
    clr();
    step(ex(0,0,0,2'b00,2'b00), "flush_idle_after");

    // ext_flush in IDLE suppresses an otherwise immediate resolve
    clr(); br(6'h06, 5'd1, 5'd2, 1'b1); ext_flush = 1;
    step(ex(0,0,0,2'b00,2'b00), "flush_suppress");
    clr(); br(6'h06, 5'd1, 5'd2, 1'b1);
    step(ex(1,0,1,2'b00,2'b00), "post_flush_resolve");

    // Reset mid-WAIT: everything low, no resolve pulse, IDLE afterwards
    clr(); br(6'h07, 5'd8, 5'd0, 1'b1); ex_memread = 1; ex_rd = 5'd8;
    step(ex(0,1,0,2'b00,2'b00), "rst_stall_c1");
    clr(); br(6'h07, 5'd8, 5'd1, 1'b1); mem_regwrite = 1; mem_rd = 5'd1; rst = 1;
    step(ex(0,0,0,2'b00,2'b00), "rst_in_wait");
    rst = 0; clr();
    step(ex(0,0,0,2'b00,2'b00), "rst_idle_after");

    // A few more resolves so the tally has both taken and not-taken entries
    br(6'h06, 5'd1, 5'd2, 1'b1); step(ex(1,0,1,2'b00,2'b00), "tally_t1");
    br(6'h07, 5'd1, 5'd2, 1'b1); step(ex(1,0,1,2'b00,2'b00), "tally_t2");
    br(6'h08, 5'd1, 5'd2, 1'b0); step(ex(1,0,0,2'b00,2'b00), "tally_n1");
    br(6'h09, 5'd1, 5'd2, 1'b1); step(ex(1,0,1,2'b00,2'b00), "tally_t3");
    br(6'h0A, 5'd1, 5'd2, 1'b0); step(ex(1,0,0,2'b00,2'b00), "tally_n2");
    clr();
    step(ex(0,0,0,2'b00,2'b00), "idle_end");

`ifdef BRANCH_STATS_EN
    chk("br_total", {16'd0, br_total}, exp_tot);
    chk("br_taken", {16'd0, br_taken}, exp_tkn);
    // Drive taken resolves until both counters must have saturated
    br(6'h06, 5'd1, 5'd2, 1'b1);
    repeat (65540) @(posedge clk);
    #1;
    chk("br_total_sat", {16'd0, br_total}, 32'h0000FFFF);
    chk("br_taken_sat", {16'd0, br_taken}, 32'h0000FFFF);
    @(posedge clk); #1;
    chk("br_total_hold", {16'd0, br_total}, 32'h0000FFFF);
    clr();
`else
    chk("br_total_tied", {16'd0, br_total}, 32'd0);
    chk("br_taken_tied", {16'd0, br_taken}, 32'd0);
`endif

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
